// File: rtl/codes.sv
// Shared decode codes and types for the execute stage.
// Function codes follow the MIPS SPECIAL funct field.
package codes;
    localparam int SIZE_W = 32;

    typedef logic [SIZE_W-1:0] size_t;
    typedef logic [5:0]        func_t;

    localparam func_t FUNC_MTHI  = 6'h11;
    localparam func_t FUNC_MTLO  = 6'h13;
    localparam func_t FUNC_MULT  = 6'h18;
    localparam func_t FUNC_MULTU = 6'h19;
    localparam func_t FUNC_DIV   = 6'h1A;
    localparam func_t FUNC_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} muldiv_state_t;

    // The magnitude of 0x80000000 wraps to itself, which is exactly right
    // when the value is read back as unsigned.
    function automatic size_t abs_val(input size_t v);
        return v[SIZE_W-1] ? -v : v;
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared shift/add datapath: a multiply step or a restoring-divide step.
// Purely combinational; the caller registers acc_next.
module muldiv_step #(
    parameter int W = 32
) (
    input  logic           div_mode,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
    output logic [2*W-1:0] acc_next
);
    logic [W:0]   sum;
    logic [W:0]   trial;
    logic [2*W:0] shl;

    always_comb begin
        sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
        shl      = {acc, 1'b0};
        trial    = shl[2*W:W] - {1'b0, operand};
        acc_next = shl[2*W-1:0];
        if (div_mode) begin
            // The remainder can carry into bit W before the trial subtract.
            // It is the borrow out of W+1 bits that decides the quotient bit.
            if (!trial[W])
                acc_next = {trial[W-1:0], shl[W-1:1], 1'b1};
        end else begin
            acc_next = {sum, acc[W-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO. A multiply or divide commits 33 cycles after
// issue, and a divide by zero commits zeros after one cycle. busy_o stalls decode, and flush_i aborts without a commit.
module muldiv_ctrl import codes::*; #(
    parameter int WIDTH = SIZE_W
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start_i,
    input  func_t funct_i,
    input  size_t rs_i,
    input  size_t rt_i,
    input  logic  flush_i,
    output logic  busy_o,
    output logic  done_o,
    output size_t mfhi_o,
    output size_t mflo_o
);
    localparam int CW = $clog2(WIDTH);

    muldiv_state_t      state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, neg, rneg, done;
    size_t              hi, lo;

    logic               is_signed, sgn_x, sgn_rs;
    size_t              rs_mag, rt_mag;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_quo, fix_rem;

    always_comb begin
        is_signed = (funct_i == FUNC_MULT) || (funct_i == FUNC_DIV);
        rs_mag    = is_signed ? abs_val(rs_i) : rs_i;
        rt_mag    = is_signed ? abs_val(rt_i) : rt_i;
        sgn_x     = is_signed & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
        sgn_rs    = is_signed & rs_i[WIDTH-1];
        fix_prod  = neg  ? -acc : acc;
        fix_quo   = neg  ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
        fix_rem   = rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    muldiv_step #(.W(WIDTH)) u_step (
        .div_mode (state == DIV),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (step_acc)
    );

    // Multiply keeps the multiplier in the low half of acc; product bits shift in from the top as it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg    <= 1'b0;
            rneg   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            if (flush_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start_i) begin
                        cnt <= '0;
                        case (funct_i)
                            FUNC_MULT, FUNC_MULTU: begin
                                acc    <= {{WIDTH{1'b0}}, rt_mag};
                                opnd   <= rs_mag;
                                neg    <= sgn_x;
                                rneg   <= 1'b0;
                                is_div <= 1'b0;
                                state  <= MUL;
                            end
                            FUNC_DIV, FUNC_DIVU: begin
                                is_div <= 1'b1;
                                opnd   <= rt_mag;
                                if (rt_i == '0) begin
                                    acc   <= '0;
                                    neg   <= 1'b0;
                                    rneg  <= 1'b0;
                                    state <= FIXUP;
                                end else begin
                                    acc   <= {{WIDTH{1'b0}}, rs_mag};
                                    neg   <= sgn_x;
                                    rneg  <= sgn_rs;
                                    state <= DIV;
                                end
                            end
                            FUNC_MTHI: hi <= rs_i;
                            FUNC_MTLO: lo <= rs_i;
                            default: ;
                        endcase
                    end
                    MUL, DIV: begin
                        acc <= step_acc;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1))
                            state <= FIXUP;
                    end
                    FIXUP: begin
                        if (is_div) begin
                            hi <= fix_rem;
                            lo <= fix_quo;
                        end else begin
                            hi <= fix_prod[2*WIDTH-1:WIDTH];
                            lo <= fix_prod[WIDTH-1:0];
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy_o = (state != IDLE);
    assign done_o = done;
    assign mfhi_o = hi;
    assign mflo_o = lo;
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer that owns the HI/LO register pair. It sits beside the combinational ALU in the execute stage and takes MULT, MULTU, DIV, DIVU, MTHI and MTLO from decode. It runs each multiply or divide over 33 cycles on one shared shift/add datapath, and reports `busy_o` so the pipeline stalls any HI/LO consumer until the result is committed.

## Interface
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.

- `clk`  in  1  — the block's single clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start_i`  in  1  — issue strobe; qualifies `funct_i`, `rs_i` and `rt_i`.
- `funct_i`  in  `func_t`  — FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU, FUNC_MTHI or FUNC_MTLO. Any other code is ignored.
- `rs_i`  in  `size_t`  — dividend, multiplicand, or MTHI/MTLO data.
- `rt_i`  in  `size_t`  — divisor or multiplier.
- `flush_i`  in  1  — abort the operation in flight; HI/LO are left unchanged.
- `busy_o`  out  1  — an operation is in flight; decode must not issue, and must stall MFHI/MFLO.
- `done_o`  out  1  — one-cycle pulse in the cycle after HI/LO are written by MULT/DIV.
- `mfhi_o`  out  `size_t`  — current HI.
- `mflo_o`  out  `size_t`  — current LO.

## Operation
- **States:** IDLE, MUL, DIV, FIXUP.
- **IDLE + start, MULT/MULTU:**
  - Latch operands. Signed variants latch absolute values and record `neg = sign(rs) ^ sign(rt)`.
  - Clear the 64-bit accumulator and the 5-bit counter, then go to MUL.
- **MUL:** each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator upper half. Then shift the accumulator/multiplier right by one, with the carry entering the top bit.
- **IDLE + start, DIV/DIVU with `rt_i != 0`:**
  - Latch magnitudes. Record `qneg = sign(rs) ^ sign(rt)` and `rneg = sign(rs)`; unsigned variants force both flags to 0.
  - Go to DIV.
- **DIV:** restoring division, one quotient bit per cycle. Shift {rem, quo} left by one, compute trial = rem − divisor; if there is no borrow, rem = trial and quo LSB = 1.
- **DIV/DIVU with `rt_i == 0`:** go straight to FIXUP with a zero result, so HI = LO = 0. This matches the existing ALU convention; no exception is raised.
- **Leaving MUL/DIV:** the counter increments each cycle; at count == WIDTH−1 the next state is FIXUP.
- **FIXUP:** apply sign correction using two's-complement negation (64-bit for the product; each 32-bit half independently for the quotient and remainder). Write HI/LO, return to IDLE, and pulse `done_o` in the next cycle.
- **MTHI/MTLO in IDLE:** write HI or LO from `rs_i` at that edge. Busy never rises and no `done_o` pulse is produced.
- **`start_i` while busy:** ignored. No state or HI/LO change.
- **`flush_i`:** in any non-IDLE state, returns the block to IDLE at the next edge without writing HI/LO and without `done_o`. In IDLE it has no effect. If `flush_i` and `start_i` are both high in the same IDLE cycle, `flush_i` wins and the start is dropped.
- **Arithmetic:** all arithmetic is modulo 2^64 (product) or 2^32 (quotient/remainder). DIV of 0x80000000 by −1 yields LO = 0x80000000, HI = 0.

## Timing
- **Reset:** state = IDLE; HI = LO = 0; `busy_o` = 0; `done_o` = 0; counter = 0. Asserting reset mid-operation discards the operation and clears HI/LO.
- **Start sampling:** edge E0 samples `start_i`. `busy_o` is high from just after E0.
- **Iterations:** edges E1..E32 are the iteration cycles; E32 enters FIXUP.
- **Commit:** edge E33 writes HI/LO. After E33, `busy_o` = 0, `done_o` = 1, and the new values appear on `mfhi_o`/`mflo_o`. Total latency is 33 cycles.
- **Divide by zero:** E0 → FIXUP; E1 commits zeros. Latency is 1 cycle.
- **Back-to-back:** a new start is accepted in the cycle where `done_o` = 1.
- **MTHI/MTLO:** the written value is visible after the issuing edge, so latency is 1 cycle.
- **Output stability:** `mfhi_o`/`mflo_o` hold their previous values throughout MUL/DIV/FIXUP.

## Structure
- **Shared package `codes`:**
  - Existing: `func_t`, `size_t`, and FUNC_MULT/MULTU/DIV/DIVU.
  - Added: FUNC_MTHI, FUNC_MTLO, and a `muldiv_state_t` enum (IDLE, MUL, DIV, FIXUP).
- **Sub-module `muldiv_step`:** combinational, one iteration. Inputs are mode, accumulator and operand; outputs are the next accumulator/quotient. Keeping it separate lets it be unit-tested exhaustively at reduced WIDTH.
- **Top level:** the FSM, counter, sign flags, FIXUP negation and the HI/LO registers.

## Test plan
- **Signed multiply:** MULT rs = 0xFFFFFFFD, rt = 7 → `busy_o` high for 33 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFEB, `done_o` pulses once.
- **Unsigned multiply:** MULTU rs = rt = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- **Signed divide:**
  - DIV rs = 0xFFFFFFF9 (−7), rt = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Divide by zero and ignored start:**
  - DIVU 7 / 0 → HI = LO = 0 one cycle after start, with one `done_o` pulse.
  - MTHI 0x12345678 → `mfhi_o` = 0x12345678 next cycle, no `busy_o`.
  - MTLO asserted while busy → ignored, LO unchanged.
- **Flush and reset mid-operation:**
  - HI = 0xA, LO = 0xB; start MULTU 3 × 5; `flush_i` at cycle 10 → IDLE, HI/LO still 0xA/0xB, no `done_o`.
  - Repeat with `rst_n` low at cycle 10 → HI = LO = 0, `busy_o` = 0 immediately.
- **Back-to-back:** start DIVU 100 / 7 in the `done_o` cycle of a preceding MULT → LO = 14, HI = 2, committed exactly 33 cycles after the second start.
